// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch PC sequencer for a combinational instruction memory,
// feeding decode through a small registered prefetch FIFO.
//
// Ports:
//   clk, rst_n          - clock (rising edge), async active-low reset
//   fetch_enable        - permits new fetches when high
//   imem_addr           - byte address to instruction memory (= fetch_pc)
//   imem_rdata          - instruction word returned in the same cycle
//   redirect_valid/_pc  - one-cycle flush and restart at redirect_pc
//   out_valid/_ready    - decode-side handshake for the FIFO head
//   out_inst, out_pc    - head instruction word and its address
//   fetch_fault         - sticky flag: illegal fetch address reached
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 88,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_enable,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        fetch_fault
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FAULT = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [31:0]     fetch_pc_q;
    logic [31:0]     fetch_pc_d;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   rd_ptr_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;

    logic [31:0]     fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]     fifo_pc_d   [FIFO_DEPTH];
    logic [31:0]     fifo_inst_q [FIFO_DEPTH];
    logic [31:0]     fifo_inst_d [FIFO_DEPTH];

    logic [31:0]     hold_pc_q;
    logic [31:0]     hold_pc_d;
    logic [31:0]     hold_inst_q;
    logic [31:0]     hold_inst_d;

    logic            pc_legal;
    logic            full;
    logic            pop;
    logic            push_try;
    logic            push;
    logic            fault_hit;

    // ------------------------------------------------------------------
    // Handshake and fetch qualification
    // ------------------------------------------------------------------
    // The 33-bit sum keeps a PC near the top of the address space from
    // wrapping into an apparently legal value.
    always_comb begin
        pc_legal  = (fetch_pc_q[1:0] == 2'b00) &&
                    (({1'b0, fetch_pc_q} + 33'd4) <= 33'(IMEM_BYTES));
        full      = (count_q == CW'(FIFO_DEPTH));
        out_valid = (count_q != '0);
        pop       = out_valid && out_ready;
        // A full FIFO can still take a word when the head leaves this cycle.
        push_try  = (state_q == S_RUN) && fetch_enable &&
                    !redirect_valid && (!full || pop);
        push      = push_try && pc_legal;
        fault_hit = push_try && !pc_legal;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN: begin
                if (redirect_valid) begin
                    state_d = S_RUN;
                end else if (fault_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_FAULT: begin
                if (redirect_valid) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        fetch_fault = (state_q == S_FAULT);
    end

    // ------------------------------------------------------------------
    // Fetch PC and FIFO bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_pc_d[i]   = fifo_pc_q[i];
            fifo_inst_d[i] = fifo_inst_q[i];
        end

        if (redirect_valid) begin
            // Flush wins over any push or pop in the same cycle.
            fetch_pc_d = redirect_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                fifo_pc_d[wr_ptr_q]   = fetch_pc_q;
                fifo_inst_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d              = wr_ptr_q + PW'(1);
                fetch_pc_d            = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Remember the current head so the outputs stay stable once it leaves.
    always_comb begin
        hold_pc_d   = hold_pc_q;
        hold_inst_d = hold_inst_q;
        if (out_valid) begin
            hold_pc_d   = fifo_pc_q[rd_ptr_q];
            hold_inst_d = fifo_inst_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q  <= RESET_PC;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            hold_pc_q   <= '0;
            hold_inst_q <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            hold_pc_q   <= hold_pc_d;
            hold_inst_q <= hold_inst_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_inst_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]   <= fifo_pc_d[i];
                fifo_inst_q[i] <= fifo_inst_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        imem_addr = fetch_pc_q;
        if (out_valid) begin
            out_pc   = fifo_pc_q[rd_ptr_q];
            out_inst = fifo_inst_q[rd_ptr_q];
        end else begin
            out_pc   = hold_pc_q;
            out_inst = hold_inst_q;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed scenarios plus random traffic for
// inst_fetch_unit, checked every cycle against a queue-based model.
module tb_inst_fetch_unit;

    localparam int DEPTH = 2;
    localparam int NWORDS = 22;

    logic        clk;
    logic        rst_n;
    logic        fetch_enable;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        fetch_fault;

    int n_checks;
    int n_errors;

    logic [31:0] rom [NWORDS];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    ent_t        m_last;
    logic [31:0] m_pc;
    bit          m_fault;

    inst_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_BYTES(88),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_enable  (fetch_enable),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .fetch_fault   (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a[31:2] < 30'(NWORDS)) return rom[a[6:2]];
        return 32'h0;
    endfunction

    always_comb imem_rdata = rom_word(imem_addr);

    function automatic bit legal(input logic [31:0] pc);
        longint unsigned e;
        e = longint'(pc) + 4;
        return (pc % 4 == 0) && (e <= 88);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc    = 32'h0;
        m_fault = 1'b0;
        m_last  = '{pc: 32'h0, inst: 32'h0};
    endtask

    task automatic model_step(input logic en, input logic rdy,
                              input logic rv, input logic [31:0] rpc);
        bit pop;
        bit room;
        if (mq.size() > 0) m_last = mq[0];
        if (rv) begin
            mq.delete();
            m_pc    = rpc;
            m_fault = 1'b0;
        end else begin
            pop  = (mq.size() > 0) && rdy;
            room = (mq.size() < DEPTH) || pop;
            if (!m_fault && en && room) begin
                if (legal(m_pc)) begin
                    mq.push_back('{pc: m_pc, inst: rom_word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end else begin
                    m_fault = 1'b1;
                end
            end
            if (pop) void'(mq.pop_front());
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_inst", out_inst, mq[0].inst);
        end else begin
            chk("hold_pc", out_pc, m_last.pc);
            chk("hold_inst", out_inst, m_last.inst);
        end
        chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
        chk("imem_addr", imem_addr, m_pc);
    endtask

    // Inputs change at negedge; outputs are checked 1ns later, and the
    // model advances on the following rising edge.
    task automatic cycle(input logic en, input logic rdy,
                         input logic rv, input logic [31:0] rpc);
        fetch_enable   = en;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        check_outputs();
        @(posedge clk);
        model_step(en, rdy, rv, rpc);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic en, input logic rdy);
        fetch_enable   = en;
        out_ready      = rdy;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        rst_n          = 1'b0;
        model_reset();
        #1;
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_inst", out_inst, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_fault", 32'(fetch_fault), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rom[0]  = 32'h00140413; rom[1]  = 32'h00043903;
        rom[2]  = 32'h04b40863; rom[3]  = 32'h00241493;
        rom[4]  = 32'h009504b3; rom[5]  = 32'h0004a983;
        rom[6]  = 32'h0044aa03; rom[7]  = 32'h013a5863;
        rom[8]  = 32'h02be8663; rom[9]  = 32'h001e8e93;
        rom[10] = 32'h0144a023; rom[11] = 32'h0134a223;
        rom[12] = 32'h00100293; rom[13] = 32'h00140413;
        rom[14] = 32'hfcb44ee3; rom[15] = 32'h00028463;
        rom[16] = 32'h00000513; rom[17] = 32'h00008067;
        rom[18] = 32'hfff58593; rom[19] = 32'h00140413;
        rom[20] = 32'hfc0592e3; rom[21] = 32'hfa000ae3;

        rst_n = 1'b1;
        @(negedge clk);

        // Straight-line fetch at full throughput
        do_reset(1'b1, 1'b1);
        cycle(1, 1, 0, 0);
        chk("seq_pc0", out_pc, 32'h0);
        chk("seq_inst0", out_inst, 32'h00140413);
        cycle(1, 1, 0, 0);
        chk("seq_pc1", out_pc, 32'h4);
        chk("seq_inst1", out_inst, 32'h00043903);
        cycle(1, 1, 0, 0);
        chk("seq_pc2", out_pc, 32'h8);
        chk("seq_inst2", out_inst, 32'h04b40863);

        // Back-pressure: FIFO saturates, PC parks at 0x08
        do_reset(1'b1, 1'b0);
        repeat (6) cycle(1, 0, 0, 0);
        chk("bp_addr", imem_addr, 32'h8);
        chk("bp_head", out_pc, 32'h0);
        repeat (4) cycle(1, 1, 0, 0);

        // Redirect while full and draining
        repeat (2) cycle(1, 0, 0, 0);
        cycle(1, 1, 1, 32'h20);
        chk("rd_flush", 32'(out_valid), 32'h0);
        cycle(1, 1, 0, 0);
        chk("rd_pc", out_pc, 32'h20);
        chk("rd_inst", out_inst, 32'h02be8663);
        cycle(1, 1, 0, 0);
        chk("rd_pc1", out_pc, 32'h24);
        chk("rd_inst1", out_inst, 32'h001e8e93);

        // Run off the end of memory
        repeat (18) cycle(1, 1, 0, 0);
        chk("end_fault", 32'(fetch_fault), 32'h1);
        chk("end_addr", imem_addr, 32'h58);
        cycle(1, 1, 1, 32'h4c);
        chk("end_clr", 32'(fetch_fault), 32'h0);
        cycle(1, 1, 0, 0);
        chk("end_pc", out_pc, 32'h4c);
        chk("end_inst", out_inst, 32'h00140413);

        // Misaligned redirect, then recovery
        cycle(1, 1, 1, 32'h22);
        cycle(1, 1, 0, 0);
        chk("mis_fault", 32'(fetch_fault), 32'h1);
        chk("mis_valid", 32'(out_valid), 32'h0);
        cycle(1, 1, 1, 32'h0);
        chk("mis_clr", 32'(fetch_fault), 32'h0);
        repeat (3) cycle(1, 1, 0, 0);

        // Async reset with a buffered entry and the fault set
        cycle(1, 0, 1, 32'h54);
        repeat (3) cycle(1, 0, 0, 0);
        chk("pre_valid", 32'(out_valid), 32'h1);
        chk("pre_fault", 32'(fetch_fault), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_fault", 32'(fetch_fault), 32'h0);
        chk("arst_addr", imem_addr, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic        en;
            logic        rdy;
            logic        rv;
            logic [31:0] rpc;
            int          k;
            en  = ($urandom_range(0, 9) < 9);
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 99) < 6);
            k   = $urandom_range(0, 9);
            if (k < 7) rpc = 32'(4 * $urandom_range(0, NWORDS - 1));
            else if (k == 7) rpc = 32'h58;
            else if (k == 8) rpc = 32'(4 * $urandom_range(0, 20) + 2);
            else rpc = 32'hffff_fffc;
            cycle(en, rdy, rv, rpc);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
